// File: rtl/uart_pkg.sv
// UART shared definitions.
// Transmit FSM states and default frame width.
package uart_pkg;

  localparam int UART_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } uart_state_e;

endpackage

// File: rtl/tx_word_fifo.sv
// Single-clock word FIFO for the UART transmitter.
// Pointers wrap naturally; depth must be a power of two.
module tx_word_fifo #(
  parameter int W = 63,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fpga.sv
// UART transmitter: buffered words, odd parity, one bit per clk_tx.
// Frame: start, WIDTH bits LSB-first (parity last), stop, idle gap.
module uart_tx_fpga
  import uart_pkg::*;
#(
  parameter int WIDTH      = UART_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_BITS  = 2
) (
  input  logic                        clk_tx,
  input  logic                        reset,
  input  logic [WIDTH-2:0]            tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx_out,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(IDLE_BITS + 1);
  localparam logic [BW-1:0] BLAST = BW'(WIDTH);
  localparam logic [GW-1:0] GLAST = GW'(IDLE_BITS);

  uart_state_e      state_q;
  uart_state_e      state_d;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  logic [BW-1:0]    bit_q;
  logic [BW-1:0]    bit_d;
  logic [GW-1:0]    gap_q;
  logic [GW-1:0]    gap_d;
  logic             out_d;
  logic             rdy_en;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             gap_done;
  logic [WIDTH-2:0] head;

  assign tx_ready = rdy_en & ~full;
  assign push     = tx_valid & tx_ready;
  assign tx_busy  = state_q != IDLE;
  assign gap_done = gap_q == GLAST;

  tx_word_fifo #(
    .W     (WIDTH - 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_tx),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (tx_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Ready stays low until the first edge after reset release.
  always_ff @(posedge clk_tx or posedge reset) begin
    if (reset) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  always_ff @(posedge clk_tx or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      tx_out  <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      tx_out  <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    out_d   = tx_out;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = START;
          pop     = 1'b1;
          sh_d    = {~^head, head};
          out_d   = 1'b0;
        end
      end
      START: begin
        state_d = DATA;
        out_d   = sh_q[0];
        sh_d    = sh_q >> 1;
        bit_d   = BW'(1);
      end
      DATA: begin
        if (bit_q == BLAST) begin
          state_d = STOP;
          out_d   = 1'b1;
        end else begin
          out_d = sh_q[0];
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 1'b1;
        end
      end
      STOP: begin
        state_d = GAP;
        out_d   = 1'b1;
        gap_d   = GW'(1);
      end
      GAP: begin
        // Waiting words launch straight from the gap end.
        if (gap_done && !empty) begin
          state_d = START;
          pop     = 1'b1;
          sh_d    = {~^head, head};
          out_d   = 1'b0;
        end else if (gap_done) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/uart_tx_fpga.md
UART_TX_FPGA -- requirements
Module: uart_tx_fpga

Interface
REQ-001 Parameter WIDTH, default 64: frame payload width in bits, parity bit included.
REQ-002 Parameter FIFO_DEPTH, default 4: input word buffer depth, power of two, minimum 2.
REQ-003 Parameter IDLE_BITS, default 2: minimum high cycles after the stop bit before the next start bit, minimum 1.
REQ-004 Port clk_tx  input  1: transmit clock, rising edge; one bit time per cycle.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port tx_data  input  WIDTH-1: packet bits [WIDTH-2:0]; the block generates the parity bit itself.
REQ-007 Port tx_valid  input  1: tx_data is valid this cycle.
REQ-008 Port tx_ready  output  1: block can accept a word this cycle.
REQ-009 Port tx_out  output  1: serial line, idle high.
REQ-010 Port tx_busy  output  1: high while a frame or its idle gap is in progress.
REQ-011 Port fifo_count  output  $clog2(FIFO_DEPTH)+1: number of words buffered and not yet started.

Function
REQ-012 Accepting a word: a word is pushed on any rising edge where tx_valid and tx_ready are both high.
REQ-013 tx_ready: equals !(fifo_count == FIFO_DEPTH); a word presented while full is not accepted, even if a pop happens in the same cycle.
REQ-014 Parity: frame bit WIDTH-1 equals XNOR-reduce of tx_data[WIDTH-2:0], giving odd parity over all WIDTH bits.
REQ-015 Frame order: start bit 0, then bits 0..WIDTH-1 LSB-first, then stop bit 1, then IDLE_BITS or more high cycles.
REQ-016 Output timing: tx_out is registered and each bit is held exactly one clk_tx cycle; frame length is WIDTH+2 cycles plus the gap.
REQ-017 FSM states and transitions:
- IDLE -> START when the FIFO is non-empty; the pop happens on that same edge.
- START -> DATA after 1 cycle.
- DATA -> STOP after WIDTH cycles.
- STOP -> GAP after 1 cycle.
- GAP -> IDLE after IDLE_BITS cycles.
REQ-018 Latency: a push at edge N into an empty FIFO with the FSM in IDLE drives the start bit from edge N+1; bit k appears from edge N+2+k; the stop bit appears from edge N+WIDTH+2.
REQ-019 Back-to-back frames: with words waiting, the next start bit begins exactly IDLE_BITS+1 cycles after the stop bit begins.
REQ-020 Push and pop in the same edge: allowed when not full; fifo_count is unchanged.
REQ-021 FIFO pointers wrap modulo FIFO_DEPTH; order is strictly FIFO.
REQ-022 Capture point: the shift register loads the popped word and the computed parity at the IDLE->START edge; later tx_data changes do not affect an in-flight frame.
REQ-023 tx_busy: high in START, DATA, STOP and GAP; low in IDLE.
REQ-024 A bit counter sized $clog2(WIDTH+1) tracks DATA; arithmetic on it never overflows its width.

Reset
REQ-025 While reset is high, all of the following hold, asynchronously:
- tx_out = 1
- tx_busy = 0
- tx_ready = 0
- fifo_count = 0
- FSM = IDLE
- FIFO contents discarded
REQ-026 Reset mid-frame aborts the frame immediately, leaving the line high with no partial stop bit.
REQ-027 tx_ready rises on the first rising edge after reset deasserts.

Structure
REQ-028 Package uart_pkg holds the FSM state enum typedef (IDLE, START, DATA, STOP, GAP) and the default frame-width constant 64, shared with the receiver.
REQ-029 The FIFO is a sub-module, tx_word_fifo: synchronous, single clock, parameterised width and depth, with push, pop, full, empty and count.

Verification
REQ-030 Single word, zero payload: tx_data=0 pushed into an idle block.
- tx_out sequence is 0, then 63 zeros, then 1 (parity), then stop 1.
- Start bit appears one cycle after the push.
REQ-031 Parity check, payload 63'h1: frame bit0=1 and bit63=0. Payload 63'h3: bit63=1.
REQ-032 Back-to-back frames: push 5 words with tx_valid held high.
- tx_ready drops after 4 words are buffered (counting the pop).
- All 5 frames appear in order, each separated by exactly IDLE_BITS high cycles after its stop bit.
REQ-033 Loopback: tx_out drives the receiver in same-clock mode with 100 random payloads.
- Every received rx_data matches the sent payload.
- parity_error stays 0 throughout.
REQ-034 Reset mid-frame: assert reset during bit 30 of frame 1 with 2 words queued.
- tx_out goes high immediately and fifo_count = 0.
- After release, a new push transmits correctly.
REQ-035 Simultaneous push and pop: with fifo_count=2, a push in the IDLE->START cycle leaves fifo_count at 2.
